des_iter_sequencer: RTL and testbench



---
 rtl/des_iter_sequencer.sv | 148 ++++++++++++++
 tb/tb_des_iter_sequencer.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/des_iter_sequencer.sv
// des_iter_sequencer: control and key-schedule wrapper for an iterative DES
// core. A single external round datapath is reused for every round; this
// block holds the L||R state and the C/D key halves, produces one round key
// per cycle (C/D rotation followed by PC-2), and handshakes on both sides.
// IP, FP and PC-1 are outside: block_in is post-IP, key_in is post-PC-1,
// and block_out is the pre-output R_n||L_n.
//
// Bit numbering follows FIPS 46-3: bit 1 is the MSB of each vector.
//
// Ports:
//   clk, rst_n             clock (rising edge), async active-low reset
//   in_valid/in_ready      job handshake; block_in, key_in, mode taken on accept
//   mode                   0 = encrypt, 1 = decrypt (decrypt only for 16 rounds)
//   block_in[63:0]         L0||R0
//   key_in[55:0]           C0||D0
//   rnd_in/rnd_key         state and round key driven to the round datapath
//   rnd_out                round datapath result {R, L^f(R,K)}, same cycle
//   out_valid/out_ready    result handshake; block_out held until accepted
//   block_out[63:0]        {R_n, L_n}
//   busy                   high while a job is running or awaiting output
//   round_idx[4:0]         rounds completed in the current job
module des_iter_sequencer #(
   parameter int NUM_ROUNDS = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        mode,
   input  logic [63:0] block_in,
   input  logic [55:0] key_in,
   output logic [63:0] rnd_in,
   output logic [47:0] rnd_key,
   input  logic [63:0] rnd_out,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [63:0] block_out,
   output logic        busy,
   output logic [4:0]  round_idx
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} st_t;

   // PC-2 selection, entries are 1-based bit numbers of C||D.
   localparam logic [5:0] PC2 [48] = '{
      6'd14, 6'd17, 6'd11, 6'd24, 6'd1,  6'd5,  6'd3,  6'd28,
      6'd15, 6'd6,  6'd21, 6'd10, 6'd23, 6'd19, 6'd12, 6'd4,
      6'd26, 6'd8,  6'd16, 6'd7,  6'd27, 6'd20, 6'd13, 6'd2,
      6'd41, 6'd52, 6'd31, 6'd37, 6'd47, 6'd55, 6'd30, 6'd40,
      6'd51, 6'd45, 6'd33, 6'd48, 6'd44, 6'd49, 6'd39, 6'd56,
      6'd34, 6'd53, 6'd46, 6'd42, 6'd50, 6'd36, 6'd29, 6'd32
   };

   st_t         st_q, st_d;
   logic [63:0] state_q;
   logic [55:0] cd_q, cd_next;
   logic        mode_q;
   logic [4:0]  rnum;
   logic [1:0]  shamt;
   logic        short_rnd;

   function automatic logic [27:0] rot28(input logic [27:0] h, input logic [1:0] n,
                                         input logic right);
      logic [27:0] r;
      case (n)
         2'd1:    r = right ? {h[0], h[27:1]}   : {h[26:0], h[27]};
         2'd2:    r = right ? {h[1:0], h[27:2]} : {h[25:0], h[27:26]};
         default: r = h;
      endcase
      return r;
   endfunction

   // Shift for the round about to execute. Decrypt walks the encrypt schedule
   // backwards with right rotations; its first round reuses C0/D0 as-is,
   // since K16 sits at a cumulative shift of 28 (identity).
   always_comb begin
      rnum      = round_idx + 5'd1;
      short_rnd = (rnum == 5'd1) || (rnum == 5'd2) || (rnum == 5'd9) || (rnum == 5'd16);
      if (!mode_q)
         shamt = short_rnd ? 2'd1 : 2'd2;
      else if (rnum == 5'd1)
         shamt = 2'd0;
      else
         shamt = short_rnd ? 2'd1 : 2'd2;
      cd_next = {rot28(cd_q[55:28], shamt, mode_q), rot28(cd_q[27:0], shamt, mode_q)};
   end

   always_comb begin
      rnd_key = '0;
      for (int i = 0; i < 48; i++)
         rnd_key[47-i] = cd_next[6'd56 - PC2[i]];
   end

   assign rnd_in = state_q;

   always_comb begin
      st_d      = st_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      block_out = '0;
      case (st_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) st_d = RUN;
         end
         RUN: begin
            busy = 1'b1;
            if (round_idx == 5'(NUM_ROUNDS - 1)) st_d = DONE;
         end
         DONE: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            block_out = {state_q[31:0], state_q[63:32]};
            if (out_ready) st_d = IDLE;
         end
         default: st_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st_q      <= IDLE;
         state_q   <= '0;
         cd_q      <= '0;
         mode_q    <= 1'b0;
         round_idx <= '0;
      end else begin
         st_q <= st_d;
         case (st_q)
            IDLE: if (in_valid) begin
               state_q   <= block_in;
               cd_q      <= key_in;
               mode_q    <= mode;
               round_idx <= '0;
            end
            RUN: begin
               state_q   <= rnd_out;
               cd_q      <= cd_next;
               round_idx <= round_idx + 5'd1;
            end
            DONE: if (out_ready) round_idx <= '0;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_des_iter_sequencer.sv
// Bench for des_iter_sequencer. Provides a behavioural DES round function as
// the external datapath, and a reference model that derives each subkey from
// the cumulative FIPS left-shift totals (decrypt = subkeys in reverse order).
module tb_des_iter_sequencer;

   localparam int E_T [48] = '{
      32, 1, 2, 3, 4, 5, 4, 5, 6, 7, 8, 9, 8, 9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
      16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25, 24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32, 1};
   localparam int P_T [32] = '{
      16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
      2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25};
   localparam int PC2_T [48] = '{
      14, 17, 11, 24, 1, 5, 3, 28, 15, 6, 21, 10, 23, 19, 12, 4, 26, 8, 16, 7, 27, 20, 13, 2,
      41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48, 44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
   localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
   // One 64-bit word per S-box row, column 0 in the top nibble.
   localparam logic [63:0] SB [32] = '{
      64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538, 64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D,
      64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5, 64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9,
      64'hA09E63F51DC7B428, 64'hD70934A6285ECBF1, 64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C,
      64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9, 64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E,
      64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986, 64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453,
      64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38, 64'h9EF528C3704A1DB6, 64'h432C95FABE17608D,
      64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86, 64'h14BDC37EAF680592, 64'h6BD814A7950FE23C,
      64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92, 64'h7B419CE206ADF358, 64'h21E74A8DFC90356B};

   localparam logic [63:0] V_BLK = 64'hCC00CCFFF0AAF0AA;
   localparam logic [55:0] V_KEY = 56'hF0CCAAF556678F;
   localparam logic [63:0] V_CT  = 64'h0A4CD99543423234;

   function automatic logic [31:0] f_fn(input logic [31:0] r, input logic [47:0] k);
      logic [47:0] x;
      logic [31:0] s, p;
      logic [5:0]  six;
      logic [63:0] row;
      for (int i = 0; i < 48; i++) x[47-i] = r[32-E_T[i]];
      x = x ^ k;
      for (int b = 0; b < 8; b++) begin
         six = x[47-6*b -: 6];
         row = SB[b*4 + int'({six[5], six[0]})];
         s[31-4*b -: 4] = row[63-4*int'(six[4:1]) -: 4];
      end
      for (int i = 0; i < 32; i++) p[31-i] = s[32-P_T[i]];
      return p;
   endfunction

   function automatic logic [63:0] round_fn(input logic [63:0] st, input logic [47:0] k);
      return {st[31:0], st[63:32] ^ f_fn(st[31:0], k)};
   endfunction

   // Subkey n (1..16) from the total left shift accumulated over rounds 1..n.
   function automatic logic [47:0] subkey(input logic [55:0] key, input int n);
      int tot;
      logic [27:0] c, d;
      logic [55:0] cd;
      logic [47:0] k;
      tot = 0;
      for (int i = 0; i < n; i++) tot += SHIFTS[i];
      c  = key[55:28];
      d  = key[27:0];
      c  = (c << tot) | (c >> (28 - tot));
      d  = (d << tot) | (d >> (28 - tot));
      cd = {c, d};
      for (int i = 0; i < 48; i++) k[47-i] = cd[56-PC2_T[i]];
      return k;
   endfunction

   logic clk = 1'b0, rst_n = 1'b0;
   always #5 clk = ~clk;

   logic        in_valid, in_ready, mode, out_valid, out_ready, busy;
   logic [63:0] block_in, rnd_in, rnd_out, block_out;
   logic [55:0] key_in;
   logic [47:0] rnd_key;
   logic [4:0]  round_idx;

   logic        in_valid1, in_ready1, mode1, out_valid1, out_ready1, busy1;
   logic [63:0] block_in1, rnd_in1, rnd_out1, block_out1;
   logic [55:0] key_in1;
   logic [47:0] rnd_key1;
   logic [4:0]  round_idx1;

   assign rnd_out  = round_fn(rnd_in, rnd_key);
   assign rnd_out1 = round_fn(rnd_in1, rnd_key1);

   des_iter_sequencer #(.NUM_ROUNDS(16)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .mode(mode),
      .block_in(block_in), .key_in(key_in), .rnd_in(rnd_in), .rnd_key(rnd_key),
      .rnd_out(rnd_out), .out_valid(out_valid), .out_ready(out_ready),
      .block_out(block_out), .busy(busy), .round_idx(round_idx));

   des_iter_sequencer #(.NUM_ROUNDS(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1), .mode(mode1),
      .block_in(block_in1), .key_in(key_in1), .rnd_in(rnd_in1), .rnd_key(rnd_key1),
      .rnd_out(rnd_out1), .out_valid(out_valid1), .out_ready(out_ready1),
      .block_out(block_out1), .busy(busy1), .round_idx(round_idx1));

   int n_chk = 0, n_fail = 0;

   task automatic test_reset();
      n_chk++;
      if ({in_ready, out_valid, busy} !== 3'b100) begin
         n_fail++; $display("FAIL reset_flags got %b want 100", {in_ready, out_valid, busy});
      end
      n_chk++;
      if (block_out !== 64'h0 || round_idx !== 5'd0 || rnd_in !== 64'h0) begin
         n_fail++; $display("FAIL reset_values got out=%h idx=%0d rin=%h want 0", block_out, round_idx, rnd_in);
      end
   endtask

   // One full 16-round job. hold = cycles out_ready stays low in DONE; poke
   // throws a conflicting in_valid into the middle of the run.
   task automatic run_job(input logic [63:0] blk, input logic [55:0] key, input logic m,
                          input int hold, input bit poke, input bit use_gold,
                          input logic [63:0] gold_out, input logic [47:0] gold_k1, input string nm);
      logic [31:0] l, r;
      logic [47:0] k;
      logic [63:0] exp_out, seen;
      @(negedge clk);
      in_valid = 1'b1; block_in = blk; key_in = key; mode = m; out_ready = (hold == 0);
      @(posedge clk); #1;
      in_valid = 1'b0; block_in = {$urandom, $urandom}; key_in = key ^ 56'h5A5A5A5A5A5A5A; mode = ~m;
      l = blk[63:32]; r = blk[31:0];
      for (int i = 1; i <= 16; i++) begin
         k = subkey(key, m ? 17 - i : i);
         n_chk++;
         if (rnd_key !== k) begin
            n_fail++; $display("FAIL %s rnd_key r%0d got %h want %h", nm, i, rnd_key, k);
         end
         n_chk++;
         if (rnd_in !== {l, r} || round_idx !== 5'(i - 1) || {in_ready, out_valid, busy} !== 3'b001) begin
            n_fail++; $display("FAIL %s run r%0d got st=%h idx=%0d flags=%b want st=%h idx=%0d flags=001",
                               nm, i, rnd_in, round_idx, {in_ready, out_valid, busy}, {l, r}, i - 1);
         end
         if (i == 1 && use_gold) begin
            n_chk++;
            if (rnd_key !== gold_k1) begin
               n_fail++; $display("FAIL %s first_key got %h want %h", nm, rnd_key, gold_k1);
            end
         end
         {l, r} = {r, l ^ f_fn(r, k)};
         if (poke && i == 4) begin
            @(negedge clk); in_valid = 1'b1; block_in = ~blk; key_in = ~key; mode = ~m;
         end
         @(posedge clk); #1;
         in_valid = 1'b0;
      end
      exp_out = {r, l};
      n_chk++;
      if (out_valid !== 1'b1 || block_out !== exp_out || round_idx !== 5'd16) begin
         n_fail++; $display("FAIL %s result got v=%b out=%h idx=%0d want v=1 out=%h idx=16",
                            nm, out_valid, block_out, round_idx, exp_out);
      end
      if (use_gold) begin
         n_chk++;
         if (block_out !== gold_out) begin
            n_fail++; $display("FAIL %s golden got %h want %h", nm, block_out, gold_out);
         end
      end
      if (!m) begin
         n_chk++;
         if (dut.cd_q !== key) begin
            n_fail++; $display("FAIL %s cd_return got %h want %h", nm, dut.cd_q, key);
         end
      end
      seen = block_out;
      for (int c = 0; c < hold; c++) begin
         @(posedge clk); #1;
         n_chk++;
         if (block_out !== seen || {in_ready, out_valid, busy} !== 3'b011) begin
            n_fail++; $display("FAIL %s hold c%0d got out=%h flags=%b want out=%h flags=011",
                               nm, c, block_out, {in_ready, out_valid, busy}, seen);
         end
      end
      if (hold > 0) begin
         @(negedge clk); out_ready = 1'b1;
      end
      @(posedge clk); #1;
      n_chk++;
      if ({in_ready, out_valid, busy} !== 3'b100 || round_idx !== 5'd0) begin
         n_fail++; $display("FAIL %s to_idle got flags=%b idx=%0d want 100 idx=0",
                            nm, {in_ready, out_valid, busy}, round_idx);
      end
      if (poke) begin
         repeat (3) begin
            @(posedge clk); #1;
            n_chk++;
            if (busy !== 1'b0) begin
               n_fail++; $display("FAIL %s second_job got busy=%b want 0", nm, busy);
            end
         end
      end
   endtask

   task automatic test_fips_encrypt();
      run_job(V_BLK, V_KEY, 1'b0, 0, 1'b0, 1'b1, V_CT, 48'h1B02EFFC7072, "enc_fips");
   endtask

   task automatic test_decrypt();
      run_job(V_CT, V_KEY, 1'b1, 0, 1'b0, 1'b1, V_BLK, 48'hCB3D8B0E17F5, "dec_fips");
   endtask

   task automatic test_backpressure();
      run_job(V_BLK, V_KEY, 1'b0, 5, 1'b0, 1'b1, V_CT, 48'h1B02EFFC7072, "backpressure");
   endtask

   task automatic test_ignored_input();
      run_job(V_BLK, V_KEY, 1'b0, 0, 1'b1, 1'b1, V_CT, 48'h1B02EFFC7072, "ignored_in");
   endtask

   task automatic test_reset_mid_job();
      @(negedge clk);
      in_valid = 1'b1; block_in = V_BLK; key_in = V_KEY; mode = 1'b0; out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (7) @(posedge clk);
      #2;
      n_chk++;
      if (round_idx !== 5'd7 || busy !== 1'b1) begin
         n_fail++; $display("FAIL rst_mid pre got idx=%0d busy=%b want 7 1", round_idx, busy);
      end
      rst_n = 1'b0;
      #1;
      n_chk++;
      if ({in_ready, out_valid, busy} !== 3'b100 || round_idx !== 5'd0 ||
          block_out !== 64'h0 || rnd_in !== 64'h0) begin
         n_fail++; $display("FAIL rst_mid async got flags=%b idx=%0d out=%h rin=%h want 100 0 0 0",
                            {in_ready, out_valid, busy}, round_idx, block_out, rnd_in);
      end
      @(negedge clk); rst_n = 1'b1;
      run_job(V_BLK, V_KEY, 1'b0, 0, 1'b0, 1'b1, V_CT, 48'h1B02EFFC7072, "after_rst");
   endtask

   task automatic test_single_round();
      logic [63:0] exp1;
      exp1 = round_fn(V_BLK, subkey(V_KEY, 1));
      exp1 = {exp1[31:0], exp1[63:32]};
      @(negedge clk);
      in_valid1 = 1'b1; block_in1 = V_BLK; key_in1 = V_KEY; mode1 = 1'b0; out_ready1 = 1'b1;
      @(posedge clk); #1;
      in_valid1 = 1'b0;
      n_chk++;
      if (rnd_key1 !== 48'h1B02EFFC7072 || out_valid1 !== 1'b0 || busy1 !== 1'b1) begin
         n_fail++; $display("FAIL nr1_run got key=%h v=%b busy=%b want 1b02effc7072 0 1", rnd_key1, out_valid1, busy1);
      end
      @(posedge clk); #1;
      n_chk++;
      if (out_valid1 !== 1'b1 || block_out1 !== 64'hEF4A6544F0AAF0AA || round_idx1 !== 5'd1) begin
         n_fail++; $display("FAIL nr1_out got v=%b out=%h idx=%0d want 1 ef4a6544f0aaf0aa 1",
                            out_valid1, block_out1, round_idx1);
      end
      n_chk++;
      if (block_out1 !== exp1) begin
         n_fail++; $display("FAIL nr1_model got %h want %h", block_out1, exp1);
      end
      @(posedge clk); #1;
      n_chk++;
      if (in_ready1 !== 1'b1 || out_valid1 !== 1'b0) begin
         n_fail++; $display("FAIL nr1_idle got rdy=%b v=%b want 1 0", in_ready1, out_valid1);
      end
   endtask

   task automatic test_random();
      logic [63:0] b, kk;
      for (int j = 0; j < 8; j++) begin
         b  = {$urandom, $urandom};
         kk = {$urandom, $urandom};
         run_job(b, kk[55:0], 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), 1'b0, 64'h0, 48'h0, "random");
      end
   endtask

   initial begin
      in_valid = 0; mode = 0; block_in = '0; key_in = '0; out_ready = 1;
      in_valid1 = 0; mode1 = 0; block_in1 = '0; key_in1 = '0; out_ready1 = 1;
      repeat (2) @(posedge clk);
      #1;
      test_reset();
      @(negedge clk); rst_n = 1'b1;
      test_fips_encrypt();
      test_decrypt();
      test_backpressure();
      test_ignored_input();
      test_reset_mid_job();
      test_single_round();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
